rs232rx_fifo: RTL and testbench

Parametrised RS-232 receiver with configurable frame format, start-bit validation, per-byte parity and framing error flags, and an internal FIFO that absorbs bursts. It sits between the board UART pin and the core's memory-mapped console/debug port. The single-entry receive path is replaced by a ready/valid FIFO with a sticky overflow report.

---
 rtl/rs232rx_fifo.sv | 228 ++++++++++++++++++++++
 tb/tb_rs232rx_fifo.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232rx_fifo.sv
// RS-232 receiver (start/data/parity/stop framing) feeding a first-word-fall-through FIFO.
// Latency: entry pushed on the edge of the last stop-bit sample; valid/level visible the cycle after.
// Backpressure: i_ready pops the head; a frame completing while full with no pop is dropped and sets sticky o_overflow.
//
// Ports:
//   i_clock, i_reset      - single clock, synchronous active-high reset
//   i_serial_in           - asynchronous RXD line, idle high
//   o_data / o_parity_error / o_framing_error - head-of-FIFO entry (valid when o_valid)
//   o_valid, i_ready      - pop on o_valid & i_ready
//   o_overflow            - sticky, a completed frame was dropped because the FIFO was full
//   o_level               - current FIFO occupancy, 0..2^FIFO_LOG2
module rs232rx_fifo #(
  parameter int FREQUENCY = 25_000_000,
  parameter int BPS       = 57_600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_LOG2 = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_serial_in,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_error,
  output logic                 o_framing_error,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overflow,
  output logic [FIFO_LOG2:0]   o_level
);

  localparam int PERIOD = (FREQUENCY + BPS / 2) / BPS;
  localparam int HALF   = PERIOD / 2;
  localparam int TW     = $clog2(PERIOD) + 1;
  localparam int BW     = $clog2(DATA_BITS + 1);
  localparam int DEPTH  = 1 << FIFO_LOG2;
  localparam int EW     = DATA_BITS + 2;

  localparam logic [TW-1:0]      T_FULL  = TW'(PERIOD - 1);
  localparam logic [TW-1:0]      T_HALF  = TW'(HALF - 1);
  localparam logic [BW-1:0]      N_DATA  = BW'(DATA_BITS);
  localparam logic [1:0]         N_STOP  = 2'(STOP_BITS);
  localparam logic               PAR_ODD = (PARITY == 1);
  localparam logic [FIFO_LOG2:0] L_FULL  = (FIFO_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // Receiver state
  state_t               r_state;
  logic                 r_rxd1;
  logic                 r_rxd2;
  logic [TW-1:0]        r_timer;
  logic [BW-1:0]        r_bitcnt;
  logic [1:0]           r_stopcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;

  // FIFO state
  logic [EW-1:0]        r_mem [DEPTH];
  logic [FIFO_LOG2-1:0] r_wptr;
  logic [FIFO_LOG2-1:0] r_rptr;
  logic [FIFO_LOG2:0]   r_level;
  logic                 r_overflow;

  logic                 w_tick;
  logic                 w_push;
  logic [EW-1:0]        w_push_dat;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_wr;

  assign w_tick = (r_timer == '0);

  // The last stop sample is folded into the framing flag combinationally so the
  // entry is written on the very edge that samples it.
  assign w_push     = (r_state == S_STOP) && w_tick && (r_stopcnt == 2'd1);
  assign w_push_dat = {r_perr, r_ferr | ~r_rxd2, r_shift};

  assign w_pop  = (r_level != '0) && i_ready;
  assign w_full = (r_level == L_FULL);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_wr   = w_push && (!w_full || w_pop);

  // Two-stage synchroniser, idle-high reset so no false start comes out of reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rxd1 <= 1'b1;
      r_rxd2 <= 1'b1;
    end else begin
      r_rxd1 <= i_serial_in;
      r_rxd2 <= r_rxd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bitcnt  <= '0;
      r_stopcnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxd2) begin
            r_state <= S_START;
            r_timer <= T_HALF;
          end
        end

        // Re-check the line at the start-bit centre to reject short glitches.
        S_START: begin
          if (w_tick) begin
            if (r_rxd2) begin
              r_state <= S_IDLE;
            end else begin
              r_state  <= S_DATA;
              r_timer  <= T_FULL;
              r_bitcnt <= N_DATA;
              r_perr   <= 1'b0;
              r_ferr   <= 1'b0;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        // LSB arrives first, so shifting in from the top leaves it at bit 0.
        S_DATA: begin
          if (w_tick) begin
            r_timer  <= T_FULL;
            r_shift  <= {r_rxd2, r_shift[DATA_BITS-1:1]};
            r_bitcnt <= r_bitcnt - BW'(1);
            if (r_bitcnt == BW'(1)) begin
              if (PARITY != 0) begin
                r_state <= S_PARITY;
              end else begin
                r_state   <= S_STOP;
                r_stopcnt <= N_STOP;
              end
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        // Total ones (data + parity bit) must be odd for odd parity, even for even.
        S_PARITY: begin
          if (w_tick) begin
            r_timer   <= T_FULL;
            r_perr    <= ((^r_shift) ^ r_rxd2) != PAR_ODD;
            r_state   <= S_STOP;
            r_stopcnt <= N_STOP;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_STOP: begin
          if (w_tick) begin
            r_timer   <= T_FULL;
            r_ferr    <= r_ferr | ~r_rxd2;
            r_stopcnt <= r_stopcnt - 2'd1;
            if (r_stopcnt == 2'd1) begin
              // A low final stop bit means the line may be in break: wait for it to go high.
              r_state <= r_rxd2 ? S_IDLE : S_BREAK;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_BREAK: begin
          if (r_rxd2) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_push_dat;
        r_wptr        <= r_wptr + FIFO_LOG2'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_LOG2'(1);
      end
      if (w_push && !w_wr) begin
        r_overflow <= 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (FIFO_LOG2 + 1)'(1);
        2'b01:   r_level <= r_level - (FIFO_LOG2 + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign {o_parity_error, o_framing_error, o_data} = r_mem[r_rptr];
  assign o_valid    = (r_level != '0);
  assign o_level    = r_level;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_rs232rx_fifo.sv
// Bench: three receivers (8N1, 7E1, 8N2) at 10 clocks per bit with a 4-entry FIFO.
// Table of single frames, hand-written multi-cycle sequences, then random 8N1 traffic
// checked against a queue of the frames sent.
module tb_rs232rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       line [3];
  logic       rdy  [3];
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic       pe   [3];
  logic       fe   [3];
  logic       vld  [3];
  logic       ovf  [3];
  logic [2:0] lvl  [3];
  logic [8:0] dat  [3];

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {2'b0, d1};
  assign dat[2] = {1'b0, d2};

  rs232rx_fifo #(.FREQUENCY(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_LOG2(2)) u_8n1 (
    .i_clock(clk), .i_reset(rst), .i_serial_in(line[0]), .o_data(d0),
    .o_parity_error(pe[0]), .o_framing_error(fe[0]), .o_valid(vld[0]),
    .i_ready(rdy[0]), .o_overflow(ovf[0]), .o_level(lvl[0]));

  rs232rx_fifo #(.FREQUENCY(1_000_000), .BPS(100_000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(1), .FIFO_LOG2(2)) u_7e1 (
    .i_clock(clk), .i_reset(rst), .i_serial_in(line[1]), .o_data(d1),
    .o_parity_error(pe[1]), .o_framing_error(fe[1]), .o_valid(vld[1]),
    .i_ready(rdy[1]), .o_overflow(ovf[1]), .o_level(lvl[1]));

  rs232rx_fifo #(.FREQUENCY(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(2), .FIFO_LOG2(2)) u_8n2 (
    .i_clock(clk), .i_reset(rst), .i_serial_in(line[2]), .o_data(d2),
    .o_parity_error(pe[2]), .o_framing_error(fe[2]), .o_valid(vld[2]),
    .i_ready(rdy[2]), .o_overflow(ovf[2]), .o_level(lvl[2]));

  int n_vec = 0;
  int n_bad = 0;
  bit prod_done = 1'b0;
  logic [8:0] model_q [$];

  typedef struct {
    int         ch;
    logic [8:0] d;
    logic       flip;
    logic       stop_low;
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input int ch, input logic b);
    line[ch] = b;
    repeat (10) @(negedge clk);
  endtask

  task automatic idle_bits(input int ch, input int n);
    line[ch] = 1'b1;
    repeat (10 * n) @(negedge clk);
  endtask

  task automatic send_frame(input int ch, input int nd, input logic [8:0] d, input logic has_par,
                            input logic pbit, input logic [1:0] stops, input int ns);
    drive_bit(ch, 1'b0);
    for (int i = 0; i < nd; i++) drive_bit(ch, d[i]);
    if (has_par) drive_bit(ch, pbit);
    for (int i = 0; i < ns; i++) drive_bit(ch, stops[i]);
  endtask

  // Frame in the channel's own format; a bad stop makes the last stop bit low.
  task automatic send_std(input int ch, input logic [8:0] d, input logic flip, input logic stop_low);
    int ns;
    int nd;
    logic [1:0] stops;
    ns    = (ch == 2) ? 2 : 1;
    nd    = (ch == 1) ? 7 : 8;
    stops = stop_low ? {1'b0, (ns == 2)} : 2'b11;
    send_frame(ch, nd, d, ch == 1, (^d[6:0]) ^ flip, stops, ns);
  endtask

  task automatic pop(input int ch);
    rdy[ch] = 1'b1;
    @(negedge clk);
    rdy[ch] = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{0, 9'h055, 1'b0, 1'b0, 9'h055, 1'b0, 1'b0};
    tbl[1] = '{0, 9'h0A3, 1'b0, 1'b0, 9'h0A3, 1'b0, 1'b0};
    tbl[2] = '{0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1};
    tbl[3] = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b1};
    tbl[4] = '{1, 9'h041, 1'b0, 1'b0, 9'h041, 1'b0, 1'b0};
    tbl[5] = '{1, 9'h041, 1'b1, 1'b0, 9'h041, 1'b1, 1'b0};
    tbl[6] = '{1, 9'h07F, 1'b0, 1'b0, 9'h07F, 1'b0, 1'b0};
    tbl[7] = '{1, 9'h000, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0};
    tbl[8] = '{1, 9'h02A, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b1};

    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      line[c] = 1'b1;
      rdy[c]  = 1'b0;
    end
    repeat (4) @(negedge clk);

    // Reset state on every instance
    for (int c = 0; c < 3; c++) begin
      check("rst_valid", vld[c], 0);
      check("rst_level", lvl[c], 0);
      check("rst_overflow", ovf[c], 0);
      check("rst_data", dat[c], 0);
      check("rst_perr", pe[c], 0);
      check("rst_ferr", fe[c], 0);
    end
    rst = 1'b0;
    idle_bits(0, 1);

    // Single-frame table
    for (int i = 0; i < 9; i++) begin
      send_std(tbl[i].ch, tbl[i].d, tbl[i].flip, tbl[i].stop_low);
      idle_bits(tbl[i].ch, 2);
      check("tbl_level", lvl[tbl[i].ch], 1);
      check("tbl_valid", vld[tbl[i].ch], 1);
      check("tbl_data", dat[tbl[i].ch], tbl[i].exp_d);
      check("tbl_perr", pe[tbl[i].ch], tbl[i].exp_pe);
      check("tbl_ferr", fe[tbl[i].ch], tbl[i].exp_fe);
      pop(tbl[i].ch);
      check("tbl_level_after_pop", lvl[tbl[i].ch], 0);
    end

    // 8N1 back-to-back with no idle time, then FWFT pops
    send_std(0, 9'h055, 1'b0, 1'b0);
    send_std(0, 9'h0A3, 1'b0, 1'b0);
    check("b2b_level", lvl[0], 2);
    rdy[0] = 1'b1;
    check("b2b_head0", dat[0], 9'h055);
    check("b2b_flags0", {pe[0], fe[0]}, 0);
    @(negedge clk);
    check("b2b_head1", dat[0], 9'h0A3);
    check("b2b_flags1", {pe[0], fe[0]}, 0);
    check("b2b_level1", lvl[0], 1);
    @(negedge clk);
    rdy[0] = 1'b0;
    check("b2b_empty", vld[0], 0);

    // 8N2: low second stop bit running into a 30-bit break, then a clean frame
    send_frame(2, 8, 9'h03C, 1'b0, 1'b0, 2'b01, 2);
    for (int i = 0; i < 30; i++) begin
      drive_bit(2, 1'b0);
      if (i == 15) check("brk_level_mid", lvl[2], 1);
    end
    check("brk_level_end", lvl[2], 1);
    idle_bits(2, 2);
    send_std(2, 9'h012, 1'b0, 1'b0);
    idle_bits(2, 1);
    check("brk_level", lvl[2], 2);
    check("brk_data0", dat[2], 9'h03C);
    check("brk_ferr0", fe[2], 1);
    check("brk_perr0", pe[2], 0);
    pop(2);
    check("brk_data1", dat[2], 9'h012);
    check("brk_ferr1", fe[2], 0);
    pop(2);
    check("brk_level_final", lvl[2], 0);

    // Glitch: 3-cycle low pulse is rejected, next frame still received
    line[0] = 1'b0;
    repeat (3) @(negedge clk);
    line[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_level", lvl[0], 0);
    check("glitch_valid", vld[0], 0);
    send_std(0, 9'h05A, 1'b0, 1'b0);
    idle_bits(0, 1);
    check("glitch_next_data", dat[0], 9'h05A);
    check("glitch_next_level", lvl[0], 1);
    pop(0);

    // Overflow: five frames into four slots
    for (int i = 1; i <= 5; i++) begin
      send_std(0, 9'(i), 1'b0, 1'b0);
      idle_bits(0, 1);
    end
    check("ovf_level", lvl[0], 4);
    check("ovf_flag", ovf[0], 1);
    check("ovf_head", dat[0], 9'h001);
    // Sixth frame completes while full; pop on exactly that edge (98th after the start bit).
    fork
      send_std(0, 9'h006, 1'b0, 1'b0);
      begin
        repeat (97) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
      end
    join
    check("ovf_pushpop_level", lvl[0], 4);
    check("ovf_pushpop_head", dat[0], 9'h002);
    begin
      logic [8:0] exp_list [4];
      exp_list = '{9'h002, 9'h003, 9'h004, 9'h006};
      for (int i = 0; i < 4; i++) begin
        check("ovf_drain", dat[0], exp_list[i]);
        pop(0);
      end
    end
    check("ovf_drained_level", lvl[0], 0);
    check("ovf_sticky", ovf[0], 1);

    // Reset in the middle of a frame
    fork
      send_std(0, 9'h0FF, 1'b0, 1'b0);
      begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    idle_bits(0, 1);
    check("mid_rst_level", lvl[0], 0);
    check("mid_rst_overflow", ovf[0], 0);
    send_std(0, 9'h081, 1'b0, 1'b0);
    idle_bits(0, 1);
    check("mid_rst_level_after", lvl[0], 1);
    check("mid_rst_data", dat[0], 9'h081);
    check("mid_rst_ferr", fe[0], 0);
    pop(0);

    // Random 8N1 traffic against a queue of sent frames, random consumer stalls
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] d;
          logic bs;
          d  = 8'($urandom_range(0, 255));
          bs = ($urandom_range(0, 4) == 0);
          model_q.push_back({bs, d});
          send_std(0, {1'b0, d}, 1'b0, bs);
          idle_bits(0, bs ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2));
        end
        prod_done = 1'b1;
      end
      begin
        int waited;
        logic r;
        logic [8:0] e;
        waited = 0;
        while (1) begin
          @(negedge clk);
          if (prod_done) begin
            if (model_q.size() == 0) break;
            waited++;
            if (waited > 300) begin
              check("rnd_drain_remaining", model_q.size(), 0);
              break;
            end
          end
          r = 1'($urandom_range(0, 1));
          rdy[0] = r;
          if (r && vld[0]) begin
            check("rnd_expected_entry", model_q.size() != 0, 1);
            if (model_q.size() != 0) begin
              e = model_q.pop_front();
              check("rnd_data", dat[0], {1'b0, e[7:0]});
              check("rnd_ferr", fe[0], e[8]);
            end
          end
        end
        rdy[0] = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("rnd_final_level", lvl[0], 0);
    check("rnd_final_overflow", ovf[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
